// File: rtl/p_pkg.sv
// p_pkg: shared types and constants for the Poly1305 key/message feeder.
//   state_t      feeder FSM states
//   WORD_W       upstream word width
//   BLK_W        block / key-half width handed to the tag engine
//   KEY_WORDS    words per 128-bit block
//   byte_mask()  keeps the low n bytes (1..4) of a word
package p_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BLK_W     = 128;
   localparam int unsigned KEY_WORDS = 4;
   localparam int unsigned LEN_W     = 32;
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned NB_W      = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDR  = 3'd1,
      STRT = 3'd2,
      LDS  = 3'd3,
      WTS  = 3'd4,
      LDM  = 3'd5,
      WTM  = 3'd6,
      WDN  = 3'd7
   } state_t;

   // Mask that keeps the first nbytes little-endian bytes of a word.
   function automatic logic [WORD_W-1:0] byte_mask(input logic [NB_W-1:0] nbytes);
      logic [WORD_W-1:0] m;
      case (nbytes)
         NB_W'(1): m = 32'h0000_00FF;
         NB_W'(2): m = 32'h0000_FFFF;
         NB_W'(3): m = 32'h00FF_FFFF;
         default:  m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/p_blk_asm.sv
// p_blk_asm: assembles up to four 32-bit words into one 128-bit block.
//   clk     clock
//   rst     synchronous active-high reset
//   clr     zero the block and the word index
//   wr      write data into the next free word slot
//   data    incoming word (little-endian bytes)
//   nbytes  valid bytes in data (1..4); the rest are zeroed
//   blk     assembled block, word k at bits 32k+31:32k
//   cnt     words loaded so far (0..4)
module p_blk_asm
   import p_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [WORD_W-1:0] data,
   input  logic [NB_W-1:0]   nbytes,
   output logic [BLK_W-1:0]  blk,
   output logic [CNT_W-1:0]  cnt
);

   logic [BLK_W-1:0] blk_q;
   logic [CNT_W-1:0] cnt_q;
   logic [6:0]       base_c;

   // Bit offset of the next word slot: 32 * index.
   assign base_c = {cnt_q[1:0], 5'b0_0000};

   // Slots never written stay zero, giving the zero fill of a short final block.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         blk_q <= '0;
         cnt_q <= '0;
      end else if (wr && (cnt_q != CNT_W'(KEY_WORDS))) begin
         blk_q[base_c +: WORD_W] <= data & byte_mask(nbytes);
         cnt_q                   <= cnt_q + CNT_W'(1);
      end
   end

   assign blk = blk_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/p_feed.sv
// p_feed: feeds r, s and the message blocks of one job to a Poly1305 tag engine.
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_cmd_start, i_cmd_len    job start pulse and byte length
//   i_wr_valid/i_wr_data      upstream word stream, o_wr_ready handshake
//   o_start, o_len_msg        engine start pulse with r on o_msg and the length
//   o_en_msg, o_msg           engine data pulse with s or a message block
//   i_rqst_msg, i_done        engine block request and tag-complete pulses
//   o_busy, o_err             job in progress, zero-length command pulse
module p_feed
   import p_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_start,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic              i_wr_valid,
   input  logic [WORD_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic              o_start,
   output logic [LEN_W-1:0]  o_len_msg,
   output logic              o_en_msg,
   output logic [BLK_W-1:0]  o_msg,
   input  logic              i_rqst_msg,
   input  logic              i_done,
   output logic              o_busy,
   output logic              o_err
);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  rem_q;
   logic              flag_q;
   logic              err_q;

   logic [BLK_W-1:0]  blk;
   logic [CNT_W-1:0]  cnt;

   logic              ready_c;
   logic              start_c;
   logic              en_c;
   logic              accept_c;
   logic              last_word_c;
   logic              clr_c;
   logic              job_ok_c;
   logic              rqst_ok_c;
   logic [NB_W-1:0]   nbytes_c;

   assign job_ok_c  = i_cmd_start && (i_cmd_len != '0);
   assign accept_c  = i_wr_valid && ready_c;
   assign rqst_ok_c = i_rqst_msg && (state_q != IDLE) && (state_q != WDN);

   // Key words are always whole; a message word carries at most the bytes still owed.
   assign nbytes_c = ((state_q != LDM) || (rem_q >= LEN_W'(4))) ? NB_W'(4) : rem_q[NB_W-1:0];

   // Word being accepted completes the buffer: fourth slot, or the job's final message word.
   assign last_word_c = (cnt == CNT_W'(KEY_WORDS - 1)) ||
                        ((state_q == LDM) && (rem_q <= LEN_W'(4)));

   // Buffer is emptied once its contents have been handed over, and held empty while idle.
   assign clr_c = start_c || en_c || (state_q == IDLE);

   p_blk_asm u_blk_asm (
      .clk    (i_clk),
      .rst    (i_rst),
      .clr    (clr_c),
      .wr     (accept_c),
      .data   (i_wr_data),
      .nbytes (nbytes_c),
      .blk    (blk),
      .cnt    (cnt)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; leaving a load state on the accepting edge gives one-cycle latency to o_en_msg.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (job_ok_c)                state_d = LDR;
         LDR:  if (accept_c && last_word_c) state_d = STRT;
         STRT:                              state_d = LDS;
         LDS:  if (accept_c && last_word_c) state_d = WTS;
         WTS:  if (en_c)                    state_d = LDM;
         LDM:  if (accept_c && last_word_c) state_d = WTM;
         WTM:  if (en_c)                    state_d = (rem_q != '0) ? LDM : WDN;
         WDN:  if (i_done)                  state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // Output decode; WTS/WTM are only entered with a full buffer.
   always_comb begin
      ready_c = 1'b0;
      start_c = 1'b0;
      en_c    = 1'b0;
      case (state_q)
         LDR, LDS: ready_c = (cnt < CNT_W'(KEY_WORDS));
         LDM:      ready_c = (cnt < CNT_W'(KEY_WORDS)) && (rem_q != '0);
         STRT:     start_c = 1'b1;
         WTS, WTM: en_c    = flag_q;
         default:  ;
      endcase
   end

   // Sticky request: a new request wins over the clear from the pulse it follows.
   always_ff @(posedge i_clk) begin
      if (i_rst) flag_q <= 1'b0;
      else       flag_q <= (flag_q && !en_c) || rqst_ok_c;
   end

   // Job length and bytes still to be loaded from the message stream.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         len_q <= '0;
         rem_q <= '0;
      end else if ((state_q == IDLE) && job_ok_c) begin
         len_q <= i_cmd_len;
         rem_q <= i_cmd_len;
      end else if ((state_q == LDM) && accept_c) begin
         rem_q <= rem_q - LEN_W'(nbytes_c);
      end
   end

   // Zero-length command pulse; commands during a job are ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= (state_q == IDLE) && i_cmd_start && (i_cmd_len == '0);
   end

   assign o_wr_ready = ready_c;
   assign o_start    = start_c;
   assign o_en_msg   = en_c;
   assign o_msg      = (start_c || en_c) ? blk : '0;
   assign o_len_msg  = len_q;
   assign o_busy     = (state_q != IDLE);
   assign o_err      = err_q;

endmodule

// File: tb/tb_p_feed.sv
// tb_p_feed: randomized self-checking bench for p_feed with a byte-level reference model.
module tb_p_feed;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_cmd_start;
   logic [31:0]  i_cmd_len;
   logic         i_wr_valid;
   logic [31:0]  i_wr_data;
   logic         o_wr_ready;
   logic         o_start;
   logic [31:0]  o_len_msg;
   logic         o_en_msg;
   logic [127:0] o_msg;
   logic         i_rqst_msg;
   logic         i_done;
   logic         o_busy;
   logic         o_err;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   p_feed dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cmd_start (i_cmd_start),
      .i_cmd_len   (i_cmd_len),
      .i_wr_valid  (i_wr_valid),
      .i_wr_data   (i_wr_data),
      .o_wr_ready  (o_wr_ready),
      .o_start     (o_start),
      .o_len_msg   (o_len_msg),
      .o_en_msg    (o_en_msg),
      .o_msg       (o_msg),
      .i_rqst_msg  (i_rqst_msg),
      .i_done      (i_done),
      .o_busy      (o_busy),
      .o_err       (o_err)
   );

   // Job data and scoreboard state.
   logic [7:0]   key_b [32];
   logic [7:0]   msg_b [$];
   logic [31:0]  words [$];
   logic [127:0] exp_r;
   logic [127:0] exp_blk [$];
   int           word_edge [$];
   int           cur_len, rq_edge, deadline, n_en, extra, zero_bad;
   bit           abort, job_end;
   logic [127:0] start_msg, last_msg;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"},   128'(o_wr_ready), 128'(0));
      check({tag, "_start"},   128'(o_start),    128'(0));
      check({tag, "_en"},      128'(o_en_msg),   128'(0));
      check({tag, "_busy"},    128'(o_busy),     128'(0));
      check({tag, "_err"},     128'(o_err),      128'(0));
      check({tag, "_msg"},     o_msg,            128'(0));
      check({tag, "_len_msg"}, 128'(o_len_msg),  128'(0));
   endtask

   task automatic random_key();
      for (int i = 0; i < 32; i++) key_b[i] = 8'($urandom);
   endtask

   task automatic load_rfc();
      logic [255:0] k;
      string        m;
      k = 256'h85d6be7857556d337f4452fe42d506a8_0103808afb0db2fd4abff6af4149f51b;
      m = "Cryptographic Forum Research Group";
      for (int i = 0; i < 32; i++) key_b[i] = k[255-8*i -: 8];
      msg_b.delete();
      for (int i = 0; i < m.len(); i++) msg_b.push_back(m[i]);
   endtask

   // Word stream plus expected r, s and message blocks straight from the byte sequence.
   task automatic build_job(input int len);
      int           nmw;
      logic [127:0] blk;
      nmw = (len + 3) / 4;
      while (msg_b.size() < 4 * nmw) msg_b.push_back(8'($urandom));
      words.delete();
      exp_blk.delete();
      for (int w = 0; w < 8; w++)
         words.push_back({key_b[4*w+3], key_b[4*w+2], key_b[4*w+1], key_b[4*w]});
      for (int w = 0; w < nmw; w++)
         words.push_back({msg_b[4*w+3], msg_b[4*w+2], msg_b[4*w+1], msg_b[4*w]});
      exp_r = '0;
      for (int i = 0; i < 16; i++) exp_r[8*i +: 8] = key_b[i];
      blk = '0;
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = key_b[16+i];
      exp_blk.push_back(blk);
      for (int b = 0; b < (len + 15) / 16; b++) begin
         blk = '0;
         for (int i = 0; i < 16; i++)
            if (16*b + i < len) blk[8*i +: 8] = msg_b[16*b + i];
         exp_blk.push_back(blk);
      end
   endtask

   task automatic feeder(input int stall_max, input int gap_idx);
      for (int w = 0; w < words.size() && !abort; w++) begin
         int gap;
         gap = (w == gap_idx) ? 10 : int'($urandom_range(0, stall_max));
         i_wr_valid = 1'b0;
         repeat (gap) @(negedge i_clk);
         i_wr_valid = 1'b1;
         i_wr_data  = words[w];
         while (!o_wr_ready && !abort && cyc < deadline) @(negedge i_clk);
         if (abort || cyc >= deadline) break;
         word_edge.push_back(cyc + 1);
         @(negedge i_clk);
      end
      // Keep offering junk: nothing more may be taken for this job.
      i_wr_valid = 1'b1;
      i_wr_data  = 32'hDEAD_BEEF;
      while (!job_end && !abort && cyc < deadline) begin
         if (o_wr_ready) extra++;
         @(negedge i_clk);
      end
      i_wr_valid = 1'b0;
   endtask

   // Engine model: requests each block after the previous pulse, then signals done.
   task automatic engine(input int rq_max);
      int rq_wait, dn_wait, last_idx, nmw, ready_edge;
      rq_wait = -1;
      dn_wait = -1;
      nmw     = (cur_len + 3) / 4;
      while (!abort && cyc < deadline) begin
         i_rqst_msg = 1'b0;
         i_done     = 1'b0;
         if (o_start) begin
            start_msg = o_msg;
            check("start_msg", o_msg, exp_r);
            check("len_msg", 128'(o_len_msg), 128'(cur_len));
            check("start_lat", 128'(cyc), 128'((word_edge.size() > 3) ? word_edge[3] : -1));
            rq_wait = $urandom_range(0, rq_max);
         end
         if (o_en_msg) begin
            last_msg   = o_msg;
            last_idx   = (n_en == 0) ? 7 : 7 + ((4*n_en < nmw) ? 4*n_en : nmw);
            ready_edge = (last_idx < word_edge.size()) ? word_edge[last_idx] : -1;
            if (rq_edge > ready_edge) ready_edge = rq_edge;
            if (n_en < exp_blk.size())
               check($sformatf("en_blk%0d", n_en), o_msg, exp_blk[n_en]);
            check($sformatf("en_lat%0d", n_en), 128'(cyc), 128'(ready_edge));
            n_en++;
            if (n_en < exp_blk.size()) rq_wait = $urandom_range(0, rq_max);
            else                       dn_wait = $urandom_range(1, 3);
         end
         if (!o_start && !o_en_msg && (o_msg != '0)) zero_bad++;
         if (rq_wait == 0) begin
            i_rqst_msg = 1'b1;
            rq_edge    = cyc + 1;
         end
         if (rq_wait >= 0) rq_wait--;
         if (dn_wait == 0) begin
            check("busy_pre_done", 128'(o_busy), 128'(1));
            i_done = 1'b1;
            @(negedge i_clk);
            i_done = 1'b0;
            check("busy_post_done", 128'(o_busy), 128'(0));
            job_end = 1'b1;
            break;
         end
         if (dn_wait > 0) dn_wait--;
         @(negedge i_clk);
      end
      i_rqst_msg = 1'b0;
      i_done     = 1'b0;
   endtask

   // Commands arriving mid-job must be ignored, including a zero-length one.
   task automatic spammer();
      repeat (6) @(negedge i_clk);
      i_cmd_start = 1'b1;
      i_cmd_len   = 32'd8;
      @(negedge i_clk);
      i_cmd_len   = 32'd0;
      @(negedge i_clk);
      i_cmd_start = 1'b0;
      check("spam_no_err", 128'(o_err), 128'(0));
      check("spam_busy", 128'(o_busy), 128'(1));
   endtask

   // Reset once two words of the first message block are in.
   task automatic aborter();
      while (!(n_en >= 1 && word_edge.size() >= 10) && cyc < deadline) @(negedge i_clk);
      @(negedge i_clk);
      abort = 1'b1;
      i_rst = 1'b1;
      @(negedge i_clk);
      check_idle_outputs("abort");
      i_rst = 1'b0;
   endtask

   task automatic run_job(input int len, input int stall_max, input int gap_idx,
                          input int rq_max, input bit spam, input bit do_abort);
      build_job(len);
      word_edge.delete();
      abort    = 1'b0;
      job_end  = 1'b0;
      n_en     = 0;
      extra    = 0;
      zero_bad = 0;
      rq_edge  = 0;
      cur_len  = len;
      deadline = cyc + 4000;
      i_cmd_start = 1'b1;
      i_cmd_len   = len;
      @(negedge i_clk);
      i_cmd_start = 1'b0;
      fork
         feeder(stall_max, gap_idx);
         engine(rq_max);
         if (spam) spammer();
         if (do_abort) aborter();
      join
      i_wr_valid = 1'b0;
      i_rqst_msg = 1'b0;
      i_done     = 1'b0;
      if (!abort) begin
         check($sformatf("job_end_len%0d", len), 128'(job_end), 128'(1));
         check($sformatf("n_en_len%0d", len), 128'(n_en), 128'(exp_blk.size()));
         check($sformatf("words_len%0d", len), 128'(word_edge.size()), 128'(words.size()));
         check("extra_words", 128'(extra), 128'(0));
         check("msg_zero_when_idle", 128'(zero_bad), 128'(0));
      end
      msg_b.delete();
      @(negedge i_clk);
   endtask

   initial begin
      i_rst       = 1'b1;
      i_cmd_start = 1'b0;
      i_cmd_len   = '0;
      i_wr_valid  = 1'b0;
      i_wr_data   = '0;
      i_rqst_msg  = 1'b0;
      i_done      = 1'b0;
      repeat (3) @(negedge i_clk);
      check_idle_outputs("reset");
      i_rst = 1'b0;
      @(negedge i_clk);

      // Zero-length command.
      i_cmd_start = 1'b1;
      i_cmd_len   = 32'd0;
      @(negedge i_clk);
      i_cmd_start = 1'b0;
      check("err_pulse", 128'(o_err), 128'(1));
      check("err_not_busy", 128'(o_busy), 128'(0));
      @(negedge i_clk);
      check("err_one_cycle", 128'(o_err), 128'(0));
      check("err_still_idle", 128'(o_busy), 128'(0));

      // RFC 8439 key and message, with ignored commands mid-job.
      load_rfc();
      run_job(34, 2, -1, 3, 1'b1, 1'b0);
      check("rfc_r", start_msg, 128'ha806d542fe52447f336d555778bed685);
      check("rfc_blk3", last_msg, 128'h7075);

      // Exactly one full block.
      random_key();
      run_job(16, 1, -1, 4, 1'b0, 1'b0);

      // Five bytes: the second word keeps only its low byte.
      random_key();
      repeat (4) msg_b.push_back(8'($urandom));
      msg_b.push_back(8'hDD);
      msg_b.push_back(8'hCC);
      msg_b.push_back(8'hBB);
      msg_b.push_back(8'hAA);
      run_job(5, 1, -1, 2, 1'b0, 1'b0);
      check("len5_upper", last_msg[127:32], 128'h0000_00DD);

      // Early request, then a 10-cycle upstream stall with two words buffered.
      random_key();
      run_job(16, 0, 10, 0, 1'b0, 1'b0);

      // Reset in the middle of message loading, then a clean RFC job.
      load_rfc();
      run_job(34, 1, -1, 2, 1'b0, 1'b1);
      load_rfc();
      run_job(34, 1, -1, 5, 1'b0, 1'b0);
      check("rfc2_r", start_msg, 128'ha806d542fe52447f336d555778bed685);
      check("rfc2_blk3", last_msg, 128'h7075);

      // Random lengths, stalls and request timing.
      repeat (25) begin
         random_key();
         run_job($urandom_range(1, 70), $urandom_range(0, 4), -1,
                 $urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
